hyperspace_binner: RTL and testbench

- Streaming spectral binning core of the HyperSpace user project, sitting between the user-area GPIO input stream and the GPIO output stream.
- Accepts 8-bit AXI-Stream-style samples and sums each group of BIN consecutive samples into one 16-bit result.
- Default frame: 2048 input bytes produce 512 output words.

---
 rtl/hyperspace_binner_pkg.sv | 23 ++
 rtl/hyperspace_binner_if.sv | 27 ++
 rtl/hyperspace_binner_acc.sv | 49 ++++
 rtl/hyperspace_binner.sv | 111 +++++++++++
 tb/tb_hyperspace_binner.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hyperspace_binner_pkg.sv
// hyperspace_binner shared definitions: default widths, bin sizing and the
// saturating accumulate used by the binning datapath.
package hyperspace_pkg;

    localparam int unsigned IN_W_D     = 8;
    localparam int unsigned OUT_W_D    = 16;
    localparam int unsigned BIN_D      = 4;
    localparam int unsigned FRAME_IN_D = 2048;
    localparam int unsigned BIN_CNT_W  = $clog2(BIN_D);

    // Sum of two unsigned values clamped to max (operands zero-extended by caller).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max}) begin
            return max;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/hyperspace_binner_if.sv
// hyperspace_binner stream interface: sample input stream and binned output
// stream. slave = core view, master = source/sink view.
interface hyperspace_binner_if
    import hyperspace_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_D,
    parameter int unsigned OUT_W = OUT_W_D
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/hyperspace_binner_acc.sv
// hs_bin_acc: running accumulator and bin counter. o_done/o_last/o_sum are
// combinational and describe the completing transfer in the current cycle.
module hs_bin_acc
    import hyperspace_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_D,
    parameter int unsigned OUT_W = OUT_W_D,
    parameter int unsigned BIN   = BIN_D
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_take,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic [OUT_W-1:0] o_sum,
    output logic             o_done,
    output logic             o_last
);
    localparam int unsigned CNT_W   = $clog2(BIN);
    localparam logic [31:0] SUM_MAX = (OUT_W >= 32) ? '1 : ((32'd1 << OUT_W) - 32'd1);

    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_sum32;
    logic             w_bin_end;

    assign w_sum32   = sat_add(32'(r_acc), 32'(i_data), SUM_MAX);
    assign o_sum     = w_sum32[OUT_W-1:0];
    assign w_bin_end = (r_cnt == CNT_W'(BIN - 1));
    assign o_done    = i_take & (w_bin_end | i_last);
    assign o_last    = i_take & i_last;

    // Accumulate accepted samples; restart the bin once a word is emitted.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_take) begin
            if (o_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= o_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hyperspace_binner.sv
// hyperspace_binner: sums each group of BIN input samples into one output
// word, with an output holding register, backpressure and frame counter.
// Optional macro HS_INPUT_BITREV_EN bit-reverses samples before summing.
module hyperspace_binner
    import hyperspace_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_D,
    parameter int unsigned OUT_W    = OUT_W_D,
    parameter int unsigned BIN      = BIN_D,
    parameter int unsigned FRAME_IN = FRAME_IN_D
) (
    input  logic                clock,
    input  logic                resetb,
    hyperspace_binner_if.slave  bus,
    output logic [15:0]         frame_cnt
);
    if ((BIN < 2) || (BIN > 16) || ((BIN & (BIN - 1)) != 0)) begin : g_bad_bin
        $error("hyperspace_binner: BIN must be a power of two in 2..16");
    end
    if (FRAME_IN == 0) begin : g_bad_frame
        $error("hyperspace_binner: FRAME_IN must be non-zero");
    end

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [IN_W-1:0]  w_sample;
    logic             w_in_ready;
    logic             w_take;
    logic             w_out_xfer;
    logic [OUT_W-1:0] w_sum;
    logic             w_done;
    logic             w_last;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [15:0]      r_frame_cnt;

    // Reset synchroniser: asynchronous assert, release after two clock edges.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef HS_INPUT_BITREV_EN
    // Undo the reversed pad ordering of the input bus.
    always_comb begin
        w_sample = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            w_sample[i] = bus.in_data[IN_W-1-i];
        end
    end
`else
    assign w_sample = bus.in_data;
`endif

    // Stall only while the holding register is full and not draining.
    assign w_in_ready = w_rst_n & ~(r_out_valid & ~bus.out_ready);
    assign w_take     = bus.in_valid & w_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    hs_bin_acc #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .BIN   (BIN)
    ) u_acc (
        .clock  (clock),
        .rst_n  (w_rst_n),
        .i_take (w_take),
        .i_data (w_sample),
        .i_last (bus.in_last),
        .o_sum  (w_sum),
        .o_done (w_done),
        .o_last (w_last)
    );

    // Output holding register; a new word may overwrite one draining this cycle.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_done) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Count frames as their last word leaves the core.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_out_xfer && r_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_hyperspace_binner.sv
// Directed self-checking bench for hyperspace_binner (default parameters).
module tb_hyperspace_binner;

    logic        clock;
    logic        resetb;
    logic [15:0] frame_cnt;
    int          checks;
    int          failures;
    int unsigned cyc;
    logic [16:0] q[$];

    hyperspace_binner_if bus ();

    hyperspace_binner dut (
        .clock     (clock),
        .resetb    (resetb),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter for throughput measurement.
    always @(posedge clock) cyc <= cyc + 1;

    // Capture every output transfer as {last, data}.
    always @(negedge clock) begin
        if (bus.out_valid && bus.out_ready) q.push_back({bus.out_last, bus.out_data});
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample transferred.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        @(negedge clock);
        while (!bus.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [15:0] d, input logic l);
        logic [16:0] w;
        if (q.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            w = q.pop_front();
            check(tag, 32'(w), 32'({l, d}));
        end
    endtask

    initial begin
        int bad;
        int lasts;
        logic [16:0] w;
        int unsigned cyc0;
        logic [15:0] rev_exp;

        checks        = 0;
        failures      = 0;
        cyc           = 0;
        resetb        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        resetb = 1'b1;
        wait_ready("ready_after_reset");

        // Basic: 01..08, last on byte 8
        for (int i = 1; i <= 8; i++) send(8'(i), (i == 8));
        drain(3);
        check_word("basic_w0", 16'h000A, 1'b0);
        check_word("basic_w1", 16'h001A, 1'b1);
        check("basic_qempty", 32'(q.size()), 32'd0);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);

        // Partial flush: 6 x 0x10, last on byte 6
        for (int i = 1; i <= 6; i++) send(8'h10, (i == 6));
        drain(3);
        check_word("partial_w0", 16'h0040, 1'b0);
        check_word("partial_w1", 16'h0020, 1'b1);
        check("partial_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure: word pending with out_ready low for 10 cycles
        bus.out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h14, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h21;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_out_data_held", 32'(bus.out_data), 32'h4A);
            check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        check("bp_no_xfer", 32'(q.size()), 32'd0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b1);
        drain(3);
        check_word("bp_w0", 16'h004A, 1'b0);
        check_word("bp_w1", 16'h008A, 1'b1);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);

        // Reset mid-bin, then 4 x 0x01
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        resetb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
            check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        resetb = 1'b1;
        q.delete();
        wait_ready("midrst_ready");
        drain(3);
        check("midrst_no_output", 32'(q.size()), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
        drain(3);
`ifdef HS_INPUT_BITREV_EN
        rev_exp = 16'h0200;
`else
        rev_exp = 16'h0004;
`endif
        check_word("midrst_word", rev_exp, 1'b0);
        check("midrst_qempty", 32'(q.size()), 32'd0);

        // Full frame: 2048 x 0xFF, last on the final byte, no bubbles
        cyc0 = cyc;
        for (int i = 0; i < 2048; i++) send(8'hFF, (i == 2047));
        check("frame_cycles", 32'(cyc - cyc0), 32'd2048);
        drain(3);
        check("frame_words", 32'(q.size()), 32'd512);
        bad   = 0;
        lasts = 0;
        w     = '0;
        while (q.size() > 0) begin
            w = q.pop_front();
            if (w[15:0] !== 16'h03FC) bad++;
            if (w[16] === 1'b1) lasts++;
        end
        check("frame_bad_data", 32'(bad), 32'd0);
        check("frame_last_count", 32'(lasts), 32'd1);
        check("frame_last_final", 32'(w[16]), 32'd1);
        check("frame_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
